// File: rtl/neuron_buffer_swap_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : neuron_buffer_swap_ctrl_if                                       |
// | Brief    : Layer request / buffer address bus of the neuron swap controller |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface neuron_buffer_swap_ctrl_if #(
  parameter int A = 7
);
  logic         start;
  logic [A:0]   layerLen;
  logic         stall;
  logic         readBufferSelect;
  logic [A-1:0] readBuffAddress;
  logic         readValid;
  logic [A-1:0] writeBuffAddress;
  logic         writeEnable;
  logic         busy;
  logic         done;

  modport master (
    output start, layerLen, stall,
    input  readBufferSelect, readBuffAddress, readValid,
    input  writeBuffAddress, writeEnable, busy, done
  );

  modport slave (
    input  start, layerLen, stall,
    output readBufferSelect, readBuffAddress, readValid,
    output writeBuffAddress, writeEnable, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/neuron_buffer_swap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : neuron_buffer_swap_ctrl                                          |
// | Brief    : Ping-pong neuron buffer controller: read a layer, write results  |
// |            LAT cycles later, then swap read/write buffers                   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module neuron_buffer_swap_ctrl #(
  parameter int A   = 7,
  parameter int LAT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  neuron_buffer_swap_ctrl_if.slave ctrl_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } state_t;

  localparam logic [A:0] c_one = {{A{1'b0}}, 1'b1};

  state_t         state_q;
  logic [A:0]     len_q;
  logic [A:0]     rd_cnt_q;
  logic [A:0]     wr_cnt_q;
  logic [A:0]     wr_cnt_d;
  logic [LAT-1:0] vld_q;
  logic           sel_q;
  logic           rd_fire;
  logic           wr_fire;

  assign rd_fire  = (state_q == RUN) && !ctrl_if.stall;
  assign wr_fire  = vld_q[LAT-1] && !ctrl_if.stall;
  // Counts are A+1 bits so a full 2^A layer terminates without wrapping.
  assign wr_cnt_d = wr_cnt_q + {{A{1'b0}}, wr_fire};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      vld_q    <= '0;
      sel_q    <= 1'b0;
    end else begin
      if (!ctrl_if.stall) begin
        vld_q[0] <= rd_fire;
        for (int i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
      wr_cnt_q <= wr_cnt_d;

      case (state_q)
        IDLE: begin
          if (ctrl_if.start && (ctrl_if.layerLen != '0)) begin
            len_q    <= ctrl_if.layerLen;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (rd_fire) begin
            rd_cnt_q <= rd_cnt_q + c_one;
            if (rd_cnt_q == (len_q - c_one)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wr_cnt_d == len_q) begin
            state_q <= SWAP;
          end
        end
        SWAP: begin
          sel_q   <= ~sel_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_if.readBufferSelect = sel_q;
  assign ctrl_if.readBuffAddress  = rd_cnt_q[A-1:0];
  assign ctrl_if.readValid        = rd_fire;
  assign ctrl_if.writeBuffAddress = wr_cnt_q[A-1:0];
  assign ctrl_if.writeEnable      = wr_fire;
  assign ctrl_if.busy             = (state_q != IDLE);
  assign ctrl_if.done             = (state_q == SWAP);

endmodule
`default_nettype wire

// File: tb/tb_neuron_buffer_swap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_neuron_buffer_swap_ctrl                                       |
// | Brief    : Self-checking bench with a queue-based timing reference model    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_neuron_buffer_swap_ctrl;
  localparam int A   = 7;
  localparam int LAT = 3;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic exp_sel  = 1'b0;

  neuron_buffer_swap_ctrl_if #(.A(A)) bus ();

  neuron_buffer_swap_ctrl #(.A(A), .LAT(LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Runs one layer. Cycle 0 is the current cycle (start asserted); the model
  // says a read issues in each unstalled cycle until len reads, and each read's
  // write lands on the LAT-th unstalled cycle after it; done follows last write.
  task automatic run_layer(input int len, input int mode, input int st_at, input bit rand_start);
    int   reads, writes, done_c, act_done, act_writes, act_last_wa, cap, c;
    int   pend[$];
    bit   stl, erv, ewe, edone, finished;
    reads = 0; writes = 0; done_c = -1; act_done = -1; act_writes = 0; act_last_wa = -1;
    finished = 0;
    cap = len * 8 + LAT + 40;
    bus.start = 1'b1; bus.layerLen = (A+1)'(len); bus.stall = 1'b0;
    #3;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.readValid !== 1'b0) begin failures++; $display("FAIL idle_rv got=%0b exp=0", bus.readValid); end
    @(posedge clk); #1;
    for (c = 1; c < cap; c++) begin
      stl = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2) ? (c == st_at || c == st_at + 1) : 1'b0;
      bus.stall    = stl;
      bus.start    = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.layerLen = (A+1)'($urandom_range(0, 2**A));
      erv   = (reads < len) && !stl;
      ewe   = (pend.size() > 0) && (pend[0] == 0) && !stl;
      edone = (c == done_c);
      #3;
      checks++; if (bus.readValid !== erv) begin failures++; $display("FAIL readValid len=%0d cyc=%0d got=%0b exp=%0b", len, c, bus.readValid, erv); end
      if (erv) begin
        checks++; if (bus.readBuffAddress !== A'(reads)) begin failures++; $display("FAIL readAddr cyc=%0d got=%0d exp=%0d", c, bus.readBuffAddress, reads); end
      end
      checks++; if (bus.writeEnable !== ewe) begin failures++; $display("FAIL writeEnable len=%0d cyc=%0d got=%0b exp=%0b", len, c, bus.writeEnable, ewe); end
      if (ewe) begin
        checks++; if (bus.writeBuffAddress !== A'(writes)) begin failures++; $display("FAIL writeAddr cyc=%0d got=%0d exp=%0d", c, bus.writeBuffAddress, writes); end
      end
      checks++; if (bus.done !== edone) begin failures++; $display("FAIL done cyc=%0d got=%0b exp=%0b", c, bus.done, edone); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy cyc=%0d got=%0b exp=1", c, bus.busy); end
      checks++; if (bus.readBufferSelect !== exp_sel) begin failures++; $display("FAIL sel_hold cyc=%0d got=%0b exp=%0b", c, bus.readBufferSelect, exp_sel); end
      if (bus.done === 1'b1 && act_done < 0) act_done = c;
      if (bus.writeEnable === 1'b1) begin act_writes++; act_last_wa = int'(bus.writeBuffAddress); end
      if (ewe) begin
        void'(pend.pop_front());
        writes++;
        if (writes == len) done_c = c + 1;
      end
      if (erv) begin
        pend.push_back(LAT);
        reads++;
      end
      if (!stl) begin
        for (int i = 0; i < pend.size(); i++) if (pend[i] > 0) pend[i] = pend[i] - 1;
      end
      @(posedge clk); #1;
      if (edone) begin
        exp_sel  = ~exp_sel;
        finished = 1'b1;
        break;
      end
    end
    checks++; if (!finished) begin failures++; $display("FAIL layer_timeout len=%0d got=unfinished exp=done", len); end
    bus.start = 1'b0; bus.stall = 1'b0;
    #3;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL post_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL post_done got=%0b exp=0", bus.done); end
    checks++; if (bus.readBufferSelect !== exp_sel) begin failures++; $display("FAIL sel_swap got=%0b exp=%0b", bus.readBufferSelect, exp_sel); end
    checks++; if (act_writes != len) begin failures++; $display("FAIL write_count got=%0d exp=%0d", act_writes, len); end
    checks++; if (act_last_wa != len - 1) begin failures++; $display("FAIL last_write_addr got=%0d exp=%0d", act_last_wa, len - 1); end
    if (mode == 0) begin
      checks++; if (act_done != len + LAT + 1) begin failures++; $display("FAIL done_latency got=%0d exp=%0d", act_done, len + LAT + 1); end
    end else if (mode == 2) begin
      checks++; if (act_done != len + LAT + 3) begin failures++; $display("FAIL done_stall_delay got=%0d exp=%0d", act_done, len + LAT + 3); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.stall = 1'b1; bus.layerLen = 4;
    #3;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%0b%0b exp=00", bus.busy, bus.done); end
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
    #3;
    checks++; if (bus.readValid !== 1'b0 || bus.writeEnable !== 1'b0) begin failures++; $display("FAIL rst_rv_we got=%0b%0b exp=00", bus.readValid, bus.writeEnable); end
    checks++; if (bus.readBuffAddress !== '0 || bus.writeBuffAddress !== '0) begin failures++; $display("FAIL rst_addr got=%0d/%0d exp=0/0", bus.readBuffAddress, bus.writeBuffAddress); end
    checks++; if (bus.readBufferSelect !== 1'b0) begin failures++; $display("FAIL rst_sel got=%0b exp=0", bus.readBufferSelect); end
    exp_sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_layer();
    run_layer(4, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic sel0;
    int   d0;
    sel0 = exp_sel;
    d0   = done_cnt;
    run_layer(5, 0, 0, 1);
    run_layer(3, 0, 0, 1);
    checks++; if (bus.readBufferSelect !== sel0) begin failures++; $display("FAIL b2b_sel got=%0b exp=%0b", bus.readBufferSelect, sel0); end
    checks++; if (done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=2", done_cnt - d0); end
  endtask

  task automatic test_stall_mid_run();
    run_layer(4, 2, 2, 0);
  endtask

  task automatic test_full_length();
    run_layer(2**A, 0, 0, 0);
    run_layer(2**A, 1, 0, 1);
  endtask

  task automatic test_ignored_starts();
    for (int k = 0; k < 3; k++) begin
      bus.start = 1'b1; bus.layerLen = '0; bus.stall = 1'($urandom_range(0, 1));
      #3;
      checks++; if (bus.busy !== 1'b0 || bus.readValid !== 1'b0) begin failures++; $display("FAIL zero_len_start k=%0d got=%0b%0b exp=00", k, bus.busy, bus.readValid); end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.stall = 1'b0;
    #3;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zero_len_ignored got=%0b exp=0", bus.busy); end
    checks++; if (bus.readBufferSelect !== exp_sel) begin failures++; $display("FAIL zero_len_sel got=%0b exp=%0b", bus.readBufferSelect, exp_sel); end
    run_layer(6, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_layer($urandom_range(1, 2**A), 1, 0, 1);
    end
  endtask

  task automatic test_reset_in_drain();
    int d0;
    if (exp_sel == 1'b0) run_layer(3, 0, 0, 0);
    d0 = done_cnt;
    bus.start = 1'b1; bus.layerLen = 4; bus.stall = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #3;
    checks++; if (bus.busy !== 1'b1 || bus.readValid !== 1'b0) begin failures++; $display("FAIL drain_state got=%0b%0b exp=10", bus.busy, bus.readValid); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_sel = 1'b0;
    #3;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.writeEnable !== 1'b0 || bus.readValid !== 1'b0) begin
      failures++; $display("FAIL drain_reset_flags got=%0b%0b%0b%0b exp=0000", bus.busy, bus.done, bus.writeEnable, bus.readValid);
    end
    checks++; if (bus.readBuffAddress !== '0 || bus.writeBuffAddress !== '0) begin failures++; $display("FAIL drain_reset_addr got=%0d/%0d exp=0/0", bus.readBuffAddress, bus.writeBuffAddress); end
    checks++; if (bus.readBufferSelect !== 1'b0) begin failures++; $display("FAIL drain_reset_sel got=%0b exp=0", bus.readBufferSelect); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      #3;
      checks++; if (bus.writeEnable !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL post_abort k=%0d got=%0b%0b exp=00", k, bus.writeEnable, bus.busy); end
    end
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL abort_done_pulses got=%0d exp=%0d", done_cnt - d0, 0); end
  endtask

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.stall = 1'b0; bus.layerLen = '0;
    @(posedge clk); #1;
    test_reset();
    test_single_layer();
    test_back_to_back();
    test_stall_mid_run();
    test_full_length();
    test_ignored_starts();
    test_random();
    test_reset_in_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/neuron_buffer_swap_ctrl.md
NEURON_BUFFER_SWAP_CTRL -- requirements
Module: neuron_buffer_swap_ctrl

Interface
REQ-001 The block SHALL have parameter A, default 7, meaning the neuron buffer address width.
REQ-002 The block SHALL have parameter LAT, default 3, meaning the read-to-write pipeline latency in cycles; legal range is LAT>=1.
REQ-003 The block SHALL have port clk, input, width 1, meaning the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, width 1, meaning synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, width 1, meaning a one-cycle request to process one layer.
REQ-006 The block SHALL have port layerLen, input, width A+1, meaning the entry count for the layer, legal range 1..2^A; it is sampled only with an accepted start.
REQ-007 The block SHALL have port stall, input, width 1, meaning a downstream hold that freezes both the read and write sides.
REQ-008 The block SHALL have port readBufferSelect, output, width 1, meaning 0 = N1 is the read buffer and 1 = N2 is the read buffer.
REQ-009 The block SHALL have port readBuffAddress, output, width A, meaning the current read address.
REQ-010 The block SHALL have port readValid, output, width 1, meaning readBuffAddress is issued this cycle.
REQ-011 The block SHALL have port writeBuffAddress, output, width A, meaning the current write address.
REQ-012 The block SHALL have port writeEnable, output, width 1, meaning a write to the write buffer at writeBuffAddress this cycle.
REQ-013 The block SHALL have ports busy and done, both output, width 1; busy is high while a layer is in progress, and done is a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN, DRAIN and SWAP, and SHALL leave reset in IDLE.
REQ-015 In IDLE, a start with layerLen!=0 SHALL be accepted: the block latches layerLen, clears the read and write counters, and enters RUN on the next cycle; a start with layerLen==0 SHALL be ignored.
REQ-016 A start SHALL be ignored in every state other than IDLE.
REQ-017 In RUN, each cycle with stall=0 SHALL assert readValid=1 with readBuffAddress equal to the read count, and SHALL then increment the read count.
REQ-018 In RUN, when the read issued this cycle is entry layerLen-1, the next state SHALL be DRAIN.
REQ-019 With stall=1, readValid SHALL be 0, and the read address, the write address and the LAT-deep valid shift register SHALL all hold.
REQ-020 The LAT-deep valid shift register SHALL carry readValid; writeEnable SHALL equal its output AND NOT stall, so the first write occurs exactly LAT unstalled cycles after the first read.
REQ-021 writeBuffAddress SHALL start at 0 and increment after each writeEnable, so the write addresses follow the same 0..layerLen-1 order as the reads.
REQ-022 In DRAIN, the block SHALL move to SWAP in the cycle after the write count reaches layerLen.
REQ-023 In SWAP, the block SHALL toggle readBufferSelect, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-024 The new readBufferSelect value SHALL be visible in the cycle after done, and readBufferSelect SHALL never change in any other state.
REQ-025 busy SHALL be 1 in RUN, DRAIN and SWAP, and 0 in IDLE.
REQ-026 With no stall, start accepted at cycle t SHALL produce reads in cycles t+1..t+L, writes in cycles t+1+LAT..t+L+LAT, and done in cycle t+L+LAT+1, where L = layerLen.
REQ-027 For layerLen=2^A, the address counters SHALL reach 2^A-1 without wrapping, and the A+1-bit count compare SHALL terminate the layer correctly.
REQ-028 Outside RUN, readValid SHALL be 0, and no writes SHALL occur outside RUN or DRAIN.
REQ-029 A start in the same cycle as done SHALL be ignored; back-to-back layers SHALL require start in IDLE, which is at the earliest the cycle after done.

Reset
REQ-030 reset SHALL force the following values on the next edge: state IDLE, readBufferSelect=0, readBuffAddress=0, writeBuffAddress=0, readValid=0, writeEnable=0, busy=0, done=0, and all shift-register stages cleared.
REQ-031 A reset during RUN, DRAIN or SWAP SHALL abort the layer without a done pulse and SHALL return readBufferSelect to 0.
REQ-032 reset SHALL take priority over start and stall.

Verification
REQ-033 The bench SHALL cover: reset, then start with layerLen=4 and LAT=3, no stall -> reads 0..3 in cycles 1-4, writes 0..3 in cycles 4-7, done in cycle 8, readBufferSelect 0->1.
REQ-034 The bench SHALL cover: two consecutive layers -> readBufferSelect ends at 0, and done pulses exactly twice.
REQ-035 The bench SHALL cover: stall for 2 cycles mid-RUN -> readValid=0 and writeEnable=0 during the stall, address sequences unbroken, and done delayed by exactly 2 cycles.
REQ-036 The bench SHALL cover: layerLen=128 (A=7) -> last read and write address is 127, with exactly 128 writes and no wrap.
REQ-037 The bench SHALL cover: start with layerLen=0, and start while busy -> both ignored, with no state change.
REQ-038 The bench SHALL cover: reset asserted in DRAIN -> the next cycle shows all outputs 0, no done pulse, and readBufferSelect=0.
